// File: rtl/stepper_pkg.sv
// +-----------------------------------------------------------------------+
// | stepper_pkg: mode encodings, half-step coil table and phase helpers.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package stepper_pkg;

  localparam logic [1:0] MODE_WAVE = 2'd0;
  localparam logic [1:0] MODE_FULL = 2'd1;
  localparam logic [1:0] MODE_HALF = 2'd2;

  // Active-high coil patterns, entry n = half-step phase n (bit0 = A .. bit3 = D)
  localparam logic [7:0][3:0] COIL_TABLE = {
    4'b1001,  // 7 DA
    4'b1000,  // 6 D
    4'b1100,  // 5 CD
    4'b0100,  // 4 C
    4'b0110,  // 3 BC
    4'b0010,  // 2 B
    4'b0011,  // 1 AB
    4'b0001   // 0 A
  };

  localparam logic [3:0] COILS_OFF = 4'b0000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Half-steps to the next legal phase: wave wants even idx, full wants odd.
  function automatic logic [1:0] phase_delta(input logic [2:0] idx, input logic [1:0] mode);
    logic [1:0] d;
    case (mode)
      MODE_HALF: d = 2'd1;
      MODE_FULL: d = idx[0] ? 2'd2 : 2'd1;
      default:   d = idx[0] ? 2'd1 : 2'd2;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/step_timer.sv
// +-----------------------------------------------------------------------+
// | step_timer: counts 0..period-1 while enabled, flags the terminal      |
// | count. A period of 0 behaves as 1. Rev 1.0                            |
// +-----------------------------------------------------------------------+
`default_nettype none

module step_timer #(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PER_W-1:0] period,
  output logic             tc
);

  logic [PER_W-1:0] count;
  logic [PER_W-1:0] last;

  assign last = (period == '0) ? '0 : period - PER_W'(1);
  assign tc   = en && (count == last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + PER_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/stepper_sequencer.sv
// +-----------------------------------------------------------------------+
// | stepper_sequencer: wave/full/half-step unipolar stepper controller    |
// | with counted moves, abort, coil gate and position counter. Rev 1.0    |
// +-----------------------------------------------------------------------+
`default_nettype none

module stepper_sequencer
  import stepper_pkg::*;
#(
  parameter int PER_W      = 16,
  parameter int STEP_W     = 16,
  parameter int POS_W      = 24,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              direction,
  input  logic [1:0]        mode,
  input  logic [PER_W-1:0]  period,
  input  logic [STEP_W-1:0] steps,
  input  logic              coil_en,
  output logic [3:0]        drive,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              step_pulse,
  output logic [POS_W-1:0]  position
);

  function automatic logic [3:0] to_pins(input logic [3:0] pattern);
    return ACTIVE_LOW ? ~pattern : pattern;
  endfunction

  localparam logic [3:0] OFF_PINS = ACTIVE_LOW ? ~COILS_OFF : COILS_OFF;

  state_t             state;
  state_t             state_d;
  logic               dir_q;
  logic [1:0]         mode_q;
  logic [PER_W-1:0]   per_q;
  logic [STEP_W-1:0]  remaining;
  logic [2:0]         idx;
  logic [2:0]         idx_d;
  logic [POS_W-1:0]   pos_q;
  logic [POS_W-1:0]   pos_d;
  logic [3:0]         drive_q;
  logic [1:0]         delta;
  logic               accept;
  logic               take_step;
  logic               end_move;
  logic               end_abort;
  logic               done_due;
  logic               abort_due;
  logic               timer_en;
  logic               tc;

  assign timer_en = (state == ST_RUN) && coil_en;

  step_timer #(
    .PER_W (PER_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (timer_en),
    .clr    (accept),
    .period (per_q),
    .tc     (tc)
  );

  assign delta = phase_delta(idx, mode_q);
  assign idx_d = dir_q ? idx + 3'(delta) : idx - 3'(delta);
  assign pos_d = dir_q ? pos_q + POS_W'(delta) : pos_q - POS_W'(delta);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // stop has priority over both a pending start and a step due this cycle
  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    take_step = 1'b0;
    end_move  = 1'b0;
    end_abort = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          accept = 1'b1;
          if (steps == '0) begin
            end_move = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d   = ST_IDLE;
          end_move  = 1'b1;
          end_abort = 1'b1;
        end else if (tc) begin
          take_step = 1'b1;
          if (remaining == STEP_W'(1)) begin
            state_d  = ST_IDLE;
            end_move = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir_q      <= 1'b1;
      mode_q     <= MODE_WAVE;
      per_q      <= '0;
      remaining  <= '0;
      idx        <= '0;
      pos_q      <= '0;
      drive_q    <= to_pins(COIL_TABLE[0]);
      step_pulse <= 1'b0;
      done_due   <= 1'b0;
      abort_due  <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      step_pulse <= take_step;
      done_due   <= end_move;
      abort_due  <= end_abort;
      done       <= done_due;
      if (accept) begin
        dir_q     <= direction;
        mode_q    <= mode;
        per_q     <= period;
        remaining <= steps;
        aborted   <= 1'b0;
      end else if (abort_due) begin
        aborted <= 1'b1;
      end
      if (take_step) begin
        idx       <= idx_d;
        pos_q     <= pos_d;
        remaining <= remaining - STEP_W'(1);
        drive_q   <= to_pins(COIL_TABLE[idx_d]);
      end
    end
  end

  assign drive    = coil_en ? drive_q : OFF_PINS;
  assign busy     = (state == ST_RUN);
  assign position = pos_q;

endmodule

`default_nettype wire

// File: doc/stepper_sequencer.md
Name: stepper_sequencer

Overview:
Parametrised unipolar stepper controller. Drives four coil lines and supports three modes: wave (one-phase), full-step (two-phase) and half-step. Runs counted moves with a start/busy/done handshake, a programmable step period, abort, a coil-enable gate and a signed position counter. It sits between a NIOS-facing register block (or board buttons) and the coil driver pins.

Parameters:
- PER_W, 16: width of step period (clk cycles per step).
- STEP_W, 16: width of requested step count.
- POS_W, 24: width of signed position counter (half-step units).
- ACTIVE_LOW, 1: 1 = energised coil driven 0; 0 = energised coil driven 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle move request, accepted only when busy=0.
- stop  in  1  one-cycle abort request.
- direction  in  1  1 = forward (A->B->C->D), 0 = reverse; sampled at accepted start.
- mode  in  2  0 = wave, 1 = full, 2 = half, 3 = reserved (treated as wave); sampled at start.
- period  in  PER_W  cycles per step, sampled at start; 0 treated as 1.
- steps  in  STEP_W  number of steps in the move, sampled at start.
- coil_en  in  1  0 forces all coils off and freezes the move.
- drive  out  4  coil outputs, bit0 = A .. bit3 = D.
- busy  out  1  move in progress.
- done  out  1  one-cycle pulse at move end (normal or aborted).
- aborted  out  1  set with done when the end was caused by stop; held until next accepted start.
- step_pulse  out  1  one-cycle pulse on each phase advance.
- position  out  POS_W  signed, half-step units.

Behaviour:
- Phase index idx 0..7 walks the half-step table: 0 A, 1 AB, 2 B, 3 BC, 4 C, 5 CD, 6 D, 7 DA.
- Wave mode uses even idx; full mode uses odd idx. Each step moves idx ±2, or ±1 when idx parity mismatches the mode (this snaps to the nearest legal phase in the travel direction). Half mode: ±1. idx wraps mod 8.
- position changes by the same signed amount as idx on each step: +delta forward, −delta reverse. It wraps mod 2^POS_W.
- drive is registered from idx. With ACTIVE_LOW=1: idx0 = 4'b1110, idx1 = 4'b1100, idx7 = 4'b0110. With coil_en=0, drive = all coils off (4'b1111 when ACTIVE_LOW=1, 4'b0000 otherwise).
- Reset: idx=0, position=0, busy=0, done=0, aborted=0, step_pulse=0, drive = idx0 pattern gated by coil_en.
- FSM states:
  - IDLE: start accepted -> latch direction/mode/period/steps, clear aborted. If steps=0, done pulses next cycle and the FSM stays IDLE. Otherwise go to RUN; busy=1 from the next cycle.
  - RUN: timer counts 0..period−1. At terminal count: advance idx and position, step_pulse=1, decrement remaining, reset timer. When remaining reaches 0 after a step, go to IDLE with done=1 the following cycle.
- First step lands exactly period cycles after the start cycle; subsequent steps every period cycles.
- In RUN with coil_en=0, timer and sequence freeze and drive is off. Resume on re-enable with the timer value preserved.
- stop in RUN: go to IDLE next cycle with done=1 and aborted=1. If a step is due in the same cycle, that step is not taken. stop in IDLE is ignored. start while busy is ignored. start and stop in the same cycle while IDLE: start is ignored.
- Async reset mid-move: immediate return to reset values; no done pulse.
- idx and position persist across moves; only rst clears them.

Decomposition:
- Package stepper_pkg:
  - mode encodings (MODE_WAVE/FULL/HALF).
  - 8-entry half-step coil table.
  - all-coils-off constant.
- Sub-module step_timer (PER_W): enable/clear inputs, period input, terminal-count output.
- FSM, idx and position logic stay in the top module.

Test Plan:
- Reset check: assert rst with coil_en=1 -> drive=4'b1110, position=0, busy=0. Then coil_en=0 -> drive=4'b1111.
- Wave forward: mode=0, dir=1, period=3, steps=4 from idx0 -> drive 1101, 1011, 0111, 1110 at cycles 3, 6, 9, 12 after start; done at cycle 13; position=+8.
- Half reverse: mode=2, dir=0, period=1, steps=3 from idx0 -> drive 0110, 0111, 0011; position=−3; three step_pulses.
- Full snap: mode=1, dir=1, steps=2 from idx0 -> idx 1 (1100) then 3 (1001); position=+3.
- Abort and gate:
  - period=5, steps=10; stop after the 2nd step -> done+aborted, exactly 2 steps taken.
  - Separately, coil_en low for 7 cycles mid-move -> drive off and the step time shifts by 7.
- Edge cases:
  - steps=0 -> done one cycle after start, no step_pulse.
  - start while busy is ignored.
  - period=0 behaves as period=1.
  - Async rst mid-move clears busy without a done pulse.
